// File: rtl/fu_writeback_arbiter.sv
// rtl/fu_writeback_arbiter.sv - per-FU result FIFOs with round-robin single-result writeback broadcast
// Optional same-cycle bypass of an empty FIFO is enabled by defining WB_BYPASS_EN.

module fu_writeback_arbiter #(
  parameter int AR_SIZE    = 7,
  parameter int FU_ARRAY   = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [FU_ARRAY-1:0]          result_valid_in,
  input  logic [FU_ARRAY*AR_SIZE-1:0]  result_tag_in,
  input  logic [FU_ARRAY*32-1:0]       result_value_in,
  output logic [FU_ARRAY-1:0]          fu_ready_out,
  output logic                         reg_valid_out,
  output logic [AR_SIZE-1:0]           reg_tag_out,
  output logic [31:0]                  reg_value_out,
  output logic                         overflow_err_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = $clog2(FU_ARRAY);
  localparam int SW = RW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [AR_SIZE-1:0] r_tag_mem [FU_ARRAY][FIFO_DEPTH];
  logic [31:0]        r_val_mem [FU_ARRAY][FIFO_DEPTH];
  logic [PW-1:0]      r_wptr    [FU_ARRAY];
  logic [PW-1:0]      r_rptr    [FU_ARRAY];
  logic [CW-1:0]      r_cnt     [FU_ARRAY];
  logic [RW-1:0]      r_rr_ptr;

  logic [AR_SIZE-1:0] w_in_tag   [FU_ARRAY];
  logic [31:0]        w_in_val   [FU_ARRAY];
  logic [AR_SIZE-1:0] w_head_tag [FU_ARRAY];
  logic [31:0]        w_head_val [FU_ARRAY];
  logic [FU_ARRAY-1:0] w_in_ok;
  logic [FU_ARRAY-1:0] w_empty;
  logic [FU_ARRAY-1:0] w_full;
  logic [FU_ARRAY-1:0] w_cand;
  logic [FU_ARRAY-1:0] w_sel;
  logic [FU_ARRAY-1:0] w_pop;
  logic [FU_ARRAY-1:0] w_byp;
  logic [FU_ARRAY-1:0] w_push;
  logic [FU_ARRAY-1:0] w_drop;

  logic               w_grant;
  logic [RW-1:0]      w_gidx;
  logic [RW-1:0]      w_rr_next;
  logic [SW-1:0]      w_sum;
  logic [RW-1:0]      w_probe;
  logic [AR_SIZE-1:0] w_bc_tag;
  logic [31:0]        w_bc_val;

  for (genvar g = 0; g < FU_ARRAY; g++) begin : g_fu
    assign w_in_tag[g]   = result_tag_in[g*AR_SIZE +: AR_SIZE];
    assign w_in_val[g]   = result_value_in[g*32 +: 32];
    // Tag 0 is the hardwired-zero register: such results are silently ignored.
    assign w_in_ok[g]    = result_valid_in[g] && (w_in_tag[g] != '0);
    assign w_empty[g]    = (r_cnt[g] == '0);
    assign w_full[g]     = (r_cnt[g] == FULL_CNT);
    assign w_head_tag[g] = r_tag_mem[g][r_rptr[g]];
    assign w_head_val[g] = r_val_mem[g][r_rptr[g]];
`ifdef WB_BYPASS_EN
    assign w_cand[g]     = !w_empty[g] || w_in_ok[g];
`else
    assign w_cand[g]     = !w_empty[g];
`endif
    assign w_sel[g]      = w_grant && (w_gidx == RW'(g));
    assign w_pop[g]      = w_sel[g] && !w_empty[g];
    assign w_byp[g]      = w_sel[g] && w_empty[g];
    assign w_push[g]     = w_in_ok[g] && !w_byp[g] && (!w_full[g] || w_pop[g]);
    assign w_drop[g]     = w_in_ok[g] && w_full[g] && !w_pop[g];
  end

  assign fu_ready_out = ~w_full;

  // Round-robin search starting at r_rr_ptr; first candidate found wins.
  always_comb begin
    w_grant = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    w_probe = '0;
    for (int k = 0; k < FU_ARRAY; k++) begin
      w_sum = {1'b0, r_rr_ptr} + SW'(k);
      if (w_sum >= SW'(FU_ARRAY)) begin
        w_sum = w_sum - SW'(FU_ARRAY);
      end
      w_probe = w_sum[RW-1:0];
      if (!w_grant && w_cand[w_probe]) begin
        w_grant = 1'b1;
        w_gidx  = w_probe;
      end
    end
  end

  assign w_rr_next = (w_gidx == RW'(FU_ARRAY - 1)) ? '0 : w_gidx + RW'(1);

`ifdef WB_BYPASS_EN
  assign w_bc_tag = w_empty[w_gidx] ? w_in_tag[w_gidx] : w_head_tag[w_gidx];
  assign w_bc_val = w_empty[w_gidx] ? w_in_val[w_gidx] : w_head_val[w_gidx];
`else
  assign w_bc_tag = w_head_tag[w_gidx];
  assign w_bc_val = w_head_val[w_gidx];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FU_ARRAY; i++) begin
        r_cnt[i]  <= '0;
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
      r_rr_ptr         <= '0;
      reg_valid_out    <= 1'b0;
      reg_tag_out      <= '0;
      reg_value_out    <= '0;
      overflow_err_out <= 1'b0;
    end else begin
      for (int i = 0; i < FU_ARRAY; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + PW'(1);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + PW'(1);
        end
        if (w_push[i] && !w_pop[i]) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (w_pop[i] && !w_push[i]) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
      if (w_grant) begin
        r_rr_ptr      <= w_rr_next;
        reg_valid_out <= 1'b1;
        reg_tag_out   <= w_bc_tag;
        reg_value_out <= w_bc_val;
      end else begin
        reg_valid_out <= 1'b0;
        reg_tag_out   <= '0;
        reg_value_out <= '0;
      end
      if (|w_drop) begin
        overflow_err_out <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_ARRAY; i++) begin
      if (w_push[i]) begin
        r_tag_mem[i][r_wptr[i]] <= w_in_tag[i];
        r_val_mem[i][r_wptr[i]] <= w_in_val[i];
      end
    end
  end

endmodule

// File: tb/tb_fu_writeback_arbiter.sv
// tb/tb_fu_writeback_arbiter.sv - directed vector bench for fu_writeback_arbiter
module tb_fu_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  result_valid_in;
  logic [20:0] result_tag_in;
  logic [95:0] result_value_in;
  logic [2:0]  fu_ready_out;
  logic        reg_valid_out;
  logic [6:0]  reg_tag_out;
  logic [31:0] reg_value_out;
  logic        overflow_err_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [6:0]  t0, t1, t2;
    logic [31:0] d0, d1, d2;
    logic        ev;
    logic [6:0]  et;
    logic [31:0] ed;
    logic [2:0]  er;
    logic        eo;
  } vec_t;

  vec_t vq[$];

  fu_writeback_arbiter dut (
    .clk              (clk),
    .rstn             (rstn),
    .result_valid_in  (result_valid_in),
    .result_tag_in    (result_tag_in),
    .result_value_in  (result_value_in),
    .fu_ready_out     (fu_ready_out),
    .reg_valid_out    (reg_valid_out),
    .reg_tag_out      (reg_tag_out),
    .reg_value_out    (reg_value_out),
    .overflow_err_out (overflow_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [43:0] exp, input logic [43:0] mask);
    logic [43:0] act;
    act = {reg_valid_out, reg_tag_out, reg_value_out, fu_ready_out, overflow_err_out};
    n_vec++;
    if ((act & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s: got v=%0b tag=%0d val=%h rdy=%b ovf=%0b, expected v=%0b tag=%0d val=%h rdy=%b ovf=%0b",
               nm, act[43], act[42:36], act[35:4], act[3:1], act[0],
               exp[43], exp[42:36], exp[35:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic add(input int rst, input int v, input int t0, input int t1, input int t2,
                     input int d0, input int d1, input int d2,
                     input int ev, input int et, input int ed, input int er, input int eo);
    vec_t x;
    x.rst = 1'(rst); x.v = 3'(v);
    x.t0 = 7'(t0); x.t1 = 7'(t1); x.t2 = 7'(t2);
    x.d0 = 32'(d0); x.d1 = 32'(d1); x.d2 = 32'(d2);
    x.ev = 1'(ev); x.et = 7'(et); x.ed = 32'(ed); x.er = 3'(er); x.eo = 1'(eo);
    vq.push_back(x);
  endtask

  initial begin
    rstn = 1'b0;
    result_valid_in = '0;
    result_tag_in = '0;
    result_value_in = '0;

`ifdef WB_BYPASS_EN
    add(0, 3'b010, 0, 4, 0, 0, 2, 0,   0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 4, 2, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
    add(0, 3'b111, 5, 6, 7, 100, 200, 300, 0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 5, 100, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 6, 200, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 7, 300, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
`else
    // single FU1 result: visible two cycles later, for one cycle only
    add(0, 3'b010, 0, 4, 0, 0, 2, 0,   0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 4, 2, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
    // all three FUs at once after reset
    add(0, 3'b111, 5, 6, 7, 100, 200, 300, 0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 5, 100, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 6, 200, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 7, 300, 3'b111, 0);
    // FU0 burst with FU1/FU2 busy; rr_ptr back at 0 so FU0 wins first
    add(0, 3'b111, 10, 20, 30, 1010, 1020, 1030, 0, 0, 0, 3'b111, 0);
    add(0, 3'b111, 11, 21, 31, 1011, 1021, 1031, 0, 0, 0, 3'b111, 0);
    add(0, 3'b001, 12, 0, 0, 1012, 0, 0, 1, 10, 1010, 3'b001, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 20, 1020, 3'b010, 0);
    add(0, 3'b001, 13, 0, 0, 1013, 0, 0, 1, 30, 1030, 3'b110, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 11, 1011, 3'b110, 0);
    // FU0 full and not granted: this one is dropped
    add(0, 3'b001, 14, 0, 0, 1014, 0, 0, 1, 21, 1021, 3'b110, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 31, 1031, 3'b110, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 12, 1012, 3'b111, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 13, 1013, 3'b111, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 1);
    // tag 0 results never enqueued or broadcast
    add(0, 3'b111, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 3'b111, 0);
    add(0, 3'b001, 40, 0, 0, 40, 0, 0, 0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        1, 40, 40, 3'b111, 0);
    // four buffered results, then reset
    add(0, 3'b111, 50, 51, 52, 5, 6, 7, 0, 0, 0, 3'b111, 0);
    add(0, 3'b101, 53, 0, 55, 8, 0, 10, 0, 0, 0, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,        1, 51, 6, 3'b010, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 3'b111, 0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {1'b0, 7'd0, 32'd0, 3'b111, 1'b0}, '1);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", k), {vq[k].ev, vq[k].et, vq[k].ed, vq[k].er, vq[k].eo}, '1);
      rstn = !vq[k].rst;
      result_valid_in = vq[k].rst ? 3'b000 : vq[k].v;
      result_tag_in   = {vq[k].t2, vq[k].t1, vq[k].t0};
      result_value_in = {vq[k].d2, vq[k].d1, vq[k].d0};
    end

    // saturate all FUs until one overflows, then pulse reset mid-cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rstn = 1'b1;
      result_valid_in = 3'b111;
      result_tag_in   = {7'(62 + 3*i), 7'(61 + 3*i), 7'(60 + 3*i)};
      result_value_in = {32'(i + 300), 32'(i + 200), 32'(i + 100)};
    end
    @(negedge clk);
    result_valid_in = '0;
    result_tag_in   = '0;
    result_value_in = '0;
    chk("ovf_set", {1'b1, 7'd0, 32'd0, 3'b000, 1'b1}, {1'b1, 39'd0, 3'b000, 1'b1});
    #1 rstn = 1'b0;
    #1 chk("async_reset", {1'b0, 7'd0, 32'd0, 3'b111, 1'b0}, '1);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d", i), {1'b0, 7'd0, 32'd0, 3'b111, 1'b0}, '1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
